// File: rtl/contador_universal_pkg.sv
// Shared types for the universal counter.
// Counting modes and the run/halt state.
package contador_pkg;

   typedef enum logic [1:0] {
      M_WRAP,
      M_SAT,
      M_ONESHOT,
      M_RSVD
   } mode_t;

   typedef enum logic {
      RUN,
      HALT
   } state_t;

endpackage

// File: rtl/contador_universal.sv
// Universal up/down counter with generic modulo, load and
// wrap / saturate / one-shot terminal-count modes.
module contador_universal
   import contador_pkg::*;
#(
   parameter int WIDTH  = 8,
   parameter int MODULO = 2 ** WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             up_dn,
   input  logic             load,
   input  logic [WIDTH-1:0] d,
   input  logic [1:0]       mode,
   output logic [WIDTH-1:0] q,
   output logic             tc,
   output logic             wrap,
   output logic             done
);

   localparam logic [WIDTH-1:0] MAXV = WIDTH'(MODULO - 1);
   localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

   state_t           state;
   state_t           state_nxt;
   logic [WIDTH-1:0] q_nxt;
   logic [WIDTH-1:0] term;
   logic             wrap_nxt;
   logic             done_nxt;

   assign term = up_dn ? MAXV : '0;
   assign tc   = (q == term);

   // Reload at TERM instead of relying on overflow, so any modulo works.
   always_comb begin
      q_nxt     = q;
      wrap_nxt  = 1'b0;
      done_nxt  = done;
      state_nxt = state;
      if (load) begin
         q_nxt     = (d > MAXV) ? MAXV : d;
         done_nxt  = 1'b0;
         state_nxt = RUN;
      end else if (state == RUN && en) begin
         if (!tc) begin
            q_nxt = up_dn ? q + ONE : q - ONE;
         end else begin
            case (mode_t'(mode))
               M_SAT: begin
                  q_nxt = q;
               end
               M_ONESHOT: begin
                  state_nxt = HALT;
                  done_nxt  = 1'b1;
               end
               default: begin
                  q_nxt    = up_dn ? '0 : MAXV;
                  wrap_nxt = 1'b1;
               end
            endcase
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         q     <= '0;
         wrap  <= 1'b0;
         done  <= 1'b0;
         state <= RUN;
      end else begin
         q     <= q_nxt;
         wrap  <= wrap_nxt;
         done  <= done_nxt;
         state <= state_nxt;
      end
   end

endmodule

// File: tb/tb_contador_universal.sv
// Self-checking bench: a modulo-10 and a modulo-256 counter
// driven in parallel and compared against an integer model.
module tb_contador_universal;

   logic       clk = 1'b0;
   logic       rst, en, up_dn, load;
   logic [7:0] d;
   logic [1:0] mode;

   logic [7:0] q10, q256;
   logic       tc10, tc256, wr10, wr256, dn10, dn256;

   int n_cmp = 0;
   int n_err = 0;

   int mods [2] = '{10, 256};
   int mq   [2];
   int mw   [2];
   int md   [2];
   int mh   [2];
   int wraps256 = 0;

   always #5 clk = ~clk;

   contador_universal #(.WIDTH(8), .MODULO(10)) u10 (
      .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .load(load),
      .d(d), .mode(mode), .q(q10), .tc(tc10), .wrap(wr10), .done(dn10)
   );

   contador_universal #(.WIDTH(8), .MODULO(256)) u256 (
      .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .load(load),
      .d(d), .mode(mode), .q(q256), .tc(tc256), .wrap(wr256), .done(dn256)
   );

   task automatic chk(string tag, int obs, int exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Behavioural model: counting in plain integers modulo M.
   function automatic void model_step(int k);
      int m;
      int tgt;
      m = mods[k];
      if (rst) begin
         mq[k] = 0; mw[k] = 0; md[k] = 0; mh[k] = 0;
      end else if (load) begin
         mq[k] = (int'(d) >= m) ? m - 1 : int'(d);
         mw[k] = 0; md[k] = 0; mh[k] = 0;
      end else if (mh[k] != 0 || !en) begin
         mw[k] = 0;
      end else begin
         tgt   = up_dn ? m - 1 : 0;
         mw[k] = 0;
         if (mq[k] != tgt)
            mq[k] = up_dn ? mq[k] + 1 : mq[k] - 1;
         else if (mode == 2'd1)
            mw[k] = 0;
         else if (mode == 2'd2) begin
            mh[k] = 1; md[k] = 1;
         end else begin
            mq[k] = (mq[k] + (up_dn ? 1 : -1) + m) % m;
            mw[k] = 1;
         end
      end
   endfunction

   function automatic int mtc(int k);
      return (mq[k] == (up_dn ? mods[k] - 1 : 0)) ? 1 : 0;
   endfunction

   task automatic check_all();
      chk("q10",    int'(q10),   mq[0]);
      chk("tc10",   int'(tc10),  mtc(0));
      chk("wrap10", int'(wr10),  mw[0]);
      chk("done10", int'(dn10),  md[0]);
      chk("q256",   int'(q256),  mq[1]);
      chk("tc256",  int'(tc256), mtc(1));
      chk("wrap256",int'(wr256), mw[1]);
      chk("done256",int'(dn256), md[1]);
   endtask

   task automatic tick();
      @(posedge clk);
      model_step(0);
      model_step(1);
      #1;
      if (wr256) wraps256++;
      check_all();
   endtask

   initial begin
      rst = 1'b1; en = 1'b0; up_dn = 1'b1; load = 1'b0;
      d = 8'd0; mode = 2'd0;
      #2;
      tick();
      chk("reset_q10", int'(q10), 0);

      // wrap up, modulo 10
      rst = 1'b0; en = 1'b1;
      for (int i = 0; i < 12; i++) tick();
      chk("t1_q_end", int'(q10), 2);

      // wrap down through zero
      up_dn = 1'b0; load = 1'b1; d = 8'd2; en = 1'b0;
      tick();
      load = 1'b0; en = 1'b1;
      for (int i = 0; i < 4; i++) tick();
      chk("t2_q_end", int'(q10), 8);

      // saturate
      mode = 2'd1; up_dn = 1'b1; load = 1'b1; d = 8'd7;
      tick();
      load = 1'b0;
      for (int i = 0; i < 5; i++) tick();
      chk("t3_q_sat", int'(q10), 9);
      chk("t3_wrap", int'(wr10), 0);

      // one-shot then frozen, even after mode change
      mode = 2'd2; load = 1'b1; d = 8'd8;
      tick();
      load = 1'b0;
      for (int i = 0; i < 6; i++) tick();
      mode = 2'd0;
      for (int i = 0; i < 3; i++) tick();
      chk("t4_frozen_q", int'(q10), 9);
      chk("t4_done", int'(dn10), 1);
      load = 1'b1; d = 8'd3;
      tick();
      load = 1'b0;
      chk("t4_reload_q", int'(q10), 3);
      chk("t4_reload_done", int'(dn10), 0);

      // clamp, then reset beats load and en
      load = 1'b1; d = 8'd200;
      tick();
      chk("t5_clamp10", int'(q10), 9);
      chk("t5_noclamp256", int'(q256), 200);
      rst = 1'b1;
      tick();
      chk("t5_rst_q", int'(q10), 0);
      rst = 1'b0; load = 1'b0; mode = 2'd0; up_dn = 1'b1;

      // en toggling, 300 enabled edges on the 256 counter
      wraps256 = 0;
      for (int i = 0; i < 600; i++) begin
         en = (i % 2 == 0);
         tick();
      end
      chk("t6_q256", int'(q256), 300 % 256);
      chk("t6_wraps", wraps256, 1);

      // random mix of all controls
      for (int i = 0; i < 500; i++) begin
         rst   = ($urandom_range(0, 49) == 0);
         load  = ($urandom_range(0, 7) == 0);
         en    = ($urandom_range(0, 3) != 0);
         up_dn = $urandom_range(0, 1) != 0;
         mode  = 2'($urandom_range(0, 3));
         d     = 8'($urandom_range(0, 255));
         tick();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
